id_scanner: RTL and testbench

//  Streaming identifier recogniser, one ASCII character per accepted cycle.

---
 rtl/id_scanner.sv | 98 +++++++++
 tb/tb_id_scanner.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_scanner.sv
// id_scanner: streaming identifier recogniser for the lexer path.
// Takes one ASCII character on each edge where char_valid is high. It tracks
// whether the current token is an identifier. When an identifier ends it reports
// the token length, an overflow flag and a saturating identifier count.
module id_scanner #(
  parameter int unsigned MAX_LEN          = 32,
  parameter int unsigned LEN_W            = 6,
  parameter int unsigned CNT_W            = 16,
  parameter bit          ALLOW_UNDERSCORE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             char_valid,
  input  logic [7:0]       char,
  output logic             in_id,
  output logic             ends_digit,
  output logic             tok_done,
  output logic [LEN_W-1:0] tok_len,
  output logic             tok_ovf,
  output logic [CNT_W-1:0] tok_count
);

  typedef enum logic [1:0] {IDLE, ID_ALPHA, ID_DIGIT, BAD} state_t;

  state_t           state;
  logic [LEN_W-1:0] cur_len;
  logic             ovf;

  logic is_let;
  logic is_dig;
  logic is_und;
  logic is_start;
  logic is_del;

  // Character classification; a character that is not a letter, digit or enabled underscore is a delimiter
  always_comb begin
    is_let   = ((char >= 8'h41) && (char <= 8'h5A)) || ((char >= 8'h61) && (char <= 8'h7A));
    is_dig   = (char >= 8'h30) && (char <= 8'h39);
    is_und   = ALLOW_UNDERSCORE && (char == 8'h5F);
    is_start = is_let || is_und;
    is_del   = !(is_start || is_dig);
  end

  // Token FSM; it also registers the per-char flags and the termination results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_len    <= '0;
      ovf        <= 1'b0;
      in_id      <= 1'b0;
      ends_digit <= 1'b0;
      tok_done   <= 1'b0;
      tok_len    <= '0;
      tok_ovf    <= 1'b0;
      tok_count  <= '0;
    end else begin
      tok_done <= 1'b0;
      if (char_valid) begin
        case (state)
          IDLE: begin
            if (is_start) begin
              state      <= ID_ALPHA;
              in_id      <= 1'b1;
              ends_digit <= 1'b0;
              cur_len    <= LEN_W'(1);
            end else if (is_dig) begin
              state <= BAD;
            end
          end
          ID_ALPHA, ID_DIGIT: begin
            if (!is_del) begin
              state      <= is_dig ? ID_DIGIT : ID_ALPHA;
              ends_digit <= is_dig;
              // once the length is saturated, any further char marks overflow
              if (cur_len == LEN_W'(MAX_LEN)) ovf <= 1'b1;
              else                            cur_len <= cur_len + LEN_W'(1);
            end else begin
              state      <= IDLE;
              in_id      <= 1'b0;
              ends_digit <= 1'b0;
              tok_done   <= 1'b1;
              tok_len    <= cur_len;
              tok_ovf    <= ovf;
              if (!ovf && (tok_count != {CNT_W{1'b1}})) tok_count <= tok_count + CNT_W'(1);
              cur_len    <= '0;
              ovf        <= 1'b0;
            end
          end
          BAD: begin
            if (is_del) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_scanner.sv
// tb_id_scanner: drives three id_scanner configurations in parallel and checks them against a token-level model.
// Instance 0 uses the default configuration. Instance 1 treats '_' as a delimiter.
// Instance 2 uses MAX_LEN=4 and a 3-bit counter.
module tb_id_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       char_valid;
  logic [7:0] ch;

  logic       in_id_w [3];
  logic       ends_w  [3];
  logic       done_w  [3];
  logic       ovf_w   [3];
  logic [5:0]  len0, len1;
  logic [2:0]  len2;
  logic [15:0] cnt0, cnt1;
  logic [2:0]  cnt2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_scanner u0 (
    .clk(clk), .reset(reset), .char_valid(char_valid), .char(ch),
    .in_id(in_id_w[0]), .ends_digit(ends_w[0]), .tok_done(done_w[0]),
    .tok_len(len0), .tok_ovf(ovf_w[0]), .tok_count(cnt0));

  id_scanner #(.ALLOW_UNDERSCORE(1'b0)) u1 (
    .clk(clk), .reset(reset), .char_valid(char_valid), .char(ch),
    .in_id(in_id_w[1]), .ends_digit(ends_w[1]), .tok_done(done_w[1]),
    .tok_len(len1), .tok_ovf(ovf_w[1]), .tok_count(cnt1));

  id_scanner #(.MAX_LEN(4), .LEN_W(3), .CNT_W(3)) u2 (
    .clk(clk), .reset(reset), .char_valid(char_valid), .char(ch),
    .in_id(in_id_w[2]), .ends_digit(ends_w[2]), .tok_done(done_w[2]),
    .tok_len(len2), .tok_ovf(ovf_w[2]), .tok_count(cnt2));

  // Token-level model: a token is a maximal run of non-delimiter chars.
  // It is an identifier unless its first char is a digit.
  int m_max  [3] = '{32, 32, 4};
  bit m_und  [3] = '{1'b1, 1'b0, 1'b1};
  int m_cmax [3] = '{65535, 65535, 7};
  int run_len[3];
  bit first_dig[3];
  bit last_dig[3];
  bit e_done[3];
  bit e_ovf[3];
  int e_len[3];
  int e_cnt[3];

  function automatic bit is_del(int i, logic [7:0] c);
    bit let_c = (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    bit dig_c = (c >= "0" && c <= "9");
    bit und_c = (c == "_") && m_und[i];
    return !(let_c || dig_c || und_c);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      run_len[i] = 0; first_dig[i] = 0; last_dig[i] = 0;
      e_done[i] = 0; e_ovf[i] = 0; e_len[i] = 0; e_cnt[i] = 0;
    end
  endtask

  task automatic model_char(logic v, logic [7:0] c);
    for (int i = 0; i < 3; i++) begin
      e_done[i] = 0;
      if (v) begin
        if (is_del(i, c)) begin
          if (run_len[i] > 0 && !first_dig[i]) begin
            e_done[i] = 1;
            e_ovf[i]  = run_len[i] > m_max[i];
            e_len[i]  = (run_len[i] > m_max[i]) ? m_max[i] : run_len[i];
            if (!e_ovf[i] && e_cnt[i] < m_cmax[i]) e_cnt[i]++;
          end
          run_len[i] = 0;
        end else begin
          if (run_len[i] == 0) first_dig[i] = (c >= "0" && c <= "9");
          last_dig[i] = (c >= "0" && c <= "9");
          run_len[i]++;
        end
      end
    end
  endtask

  function automatic logic [25:0] obs(int i);
    case (i)
      0:       return {in_id_w[0], ends_w[0], done_w[0], ovf_w[0], len0, cnt0};
      1:       return {in_id_w[1], ends_w[1], done_w[1], ovf_w[1], len1, cnt1};
      default: return {in_id_w[2], ends_w[2], done_w[2], ovf_w[2], 6'(len2), 16'(cnt2)};
    endcase
  endfunction

  function automatic logic [25:0] expv(int i);
    bit id = (run_len[i] > 0) && !first_dig[i];
    return {id, id && last_dig[i], e_done[i], e_ovf[i], 6'(e_len[i]), 16'(e_cnt[i])};
  endfunction

  // Drive one input cycle, then sample just after the active edge
  task automatic step(logic v, logic [7:0] c);
    @(negedge clk);
    char_valid = v;
    ch = c;
    @(posedge clk);
    model_char(v, c);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; char_valid = 1'b0; ch = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs(i) !== 26'd0) begin
        miscompares++;
        $display("FAIL reset inst%0d obs=%h exp=0", i, obs(i));
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ab1();
    string s = "ab1 ";
    bit exp_ed[4] = '{0, 0, 1, 0};
    bit exp_id[4] = '{1, 1, 1, 0};
    for (int k = 0; k < 4; k++) begin
      step(1'b1, s[k]);
      vectors++;
      if ({in_id_w[0], ends_w[0], done_w[0]} !== {exp_id[k], exp_ed[k], 1'(k == 3)}) begin
        miscompares++;
        $display("FAIL ab1 char%0d in_id/ends/done=%b%b%b exp=%b%b%b", k,
                 in_id_w[0], ends_w[0], done_w[0], exp_id[k], exp_ed[k], k == 3);
      end
    end
    vectors++;
    if (len0 !== 6'd3 || cnt0 !== 16'd1) begin
      miscompares++;
      $display("FAIL ab1 len/count obs=%0d/%0d exp=3/1", len0, cnt0);
    end
  endtask

  task automatic test_bad();
    string s = "9x ";
    logic [15:0] c0 = cnt0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, s[k]);
      vectors++;
      if (in_id_w[0] !== 1'b0 || done_w[0] !== 1'b0 || cnt0 !== c0) begin
        miscompares++;
        $display("FAIL bad char%0d in_id=%b done=%b cnt=%0d exp 0/0/%0d", k, in_id_w[0], done_w[0], cnt0, c0);
      end
    end
  endtask

  task automatic test_underscore();
    string s = "_a2;";
    for (int k = 0; k < 4; k++) begin
      step(1'b1, s[k]);
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (obs(i) !== expv(i)) begin
          miscompares++;
          $display("FAIL underscore inst%0d char%0d obs=%h exp=%h", i, k, obs(i), expv(i));
        end
      end
    end
    vectors++;
    if (len0 !== 6'd3 || len1 !== 6'd2 || done_w[0] !== 1'b1 || done_w[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL underscore len0=%0d len1=%0d done=%b%b exp 3 2 11", len0, len1, done_w[0], done_w[1]);
    end
  endtask

  task automatic test_overflow();
    string s = "abcdef ";
    string t = "x ";
    logic [2:0] c2 = cnt2;
    for (int k = 0; k < s.len(); k++) step(1'b1, s[k]);
    vectors++;
    if (done_w[2] !== 1'b1 || ovf_w[2] !== 1'b1 || len2 !== 3'd4 || cnt2 !== c2) begin
      miscompares++;
      $display("FAIL overflow done=%b ovf=%b len=%0d cnt=%0d exp 1 1 4 %0d", done_w[2], ovf_w[2], len2, cnt2, c2);
    end
    vectors++;
    if (ovf_w[0] !== 1'b0 || len0 !== 6'd6) begin
      miscompares++;
      $display("FAIL overflow_wide ovf=%b len=%0d exp 0 6", ovf_w[0], len0);
    end
    for (int k = 0; k < t.len(); k++) step(1'b1, t[k]);
    vectors++;
    if (ovf_w[2] !== 1'b0 || len2 !== 3'd1 || cnt2 !== 3'(c2 + 3'd1)) begin
      miscompares++;
      $display("FAIL overflow_next ovf=%b len=%0d cnt=%0d exp 0 1 %0d", ovf_w[2], len2, cnt2, c2 + 3'd1);
    end
  endtask

  task automatic test_gap();
    step(1'b1, "a");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, "?");
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (obs(i) !== expv(i) || in_id_w[i] !== 1'b1) begin
          miscompares++;
          $display("FAIL gap inst%0d cyc%0d obs=%h exp=%h", i, k, obs(i), expv(i));
        end
      end
    end
    step(1'b1, "1");
    step(1'b1, " ");
    vectors++;
    if (len0 !== 6'd2 || done_w[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL gap len=%0d done=%b exp 2 1", len0, done_w[0]);
    end
  endtask

  task automatic test_reset_mid();
    string s = "abc";
    for (int k = 0; k < 3; k++) step(1'b1, s[k]);
    @(negedge clk);
    char_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs(i) !== 26'd0) begin
        miscompares++;
        $display("FAIL reset_mid inst%0d obs=%h exp=0", i, obs(i));
      end
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, " ");
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (done_w[i] !== 1'b0 || obs(i) !== expv(i)) begin
        miscompares++;
        $display("FAIL reset_mid_del inst%0d obs=%h exp=%h", i, obs(i), expv(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[8] = '{"a", 8'h5B, "b", 8'h60, 8'h60, 8'h5B, "c", "_"};
    for (int k = 0; k < 8; k++) begin
      step(1'b1, seq[k]);
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (obs(i) !== expv(i)) begin
          miscompares++;
          $display("FAIL back_to_back inst%0d char%0d obs=%h exp=%h", i, k, obs(i), expv(i));
        end
      end
    end
    step(1'b1, " ");
  endtask

  task automatic test_random();
    logic [7:0] c;
    logic v;
    int r;
    for (int n = 0; n < 800; n++) begin
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: c = 8'($urandom_range(0, 1) ? $urandom_range(65, 90) : $urandom_range(97, 122));
        4, 5:       c = 8'($urandom_range(48, 57));
        6:          c = 8'h5F;
        7:          c = 8'h20;
        8:          c = $urandom_range(0, 1) ? 8'h5B : 8'h60;
        default:    c = 8'($urandom_range(0, 255));
      endcase
      step(v, c);
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (obs(i) !== expv(i)) begin
          miscompares++;
          $display("FAIL random n%0d inst%0d char=%h v=%b obs=%h exp=%h", n, i, c, v, obs(i), expv(i));
        end
      end
    end
    step(1'b1, " ");
  endtask

  task automatic test_count_sat();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, "q");
      step(1'b1, " ");
    end
    vectors++;
    if (cnt2 !== 3'd7 || cnt0 !== 16'(e_cnt[0])) begin
      miscompares++;
      $display("FAIL count_sat cnt2=%0d cnt0=%0d exp 7 %0d", cnt2, cnt0, e_cnt[0]);
    end
  endtask

  initial begin
    test_reset();
    test_ab1();
    test_bad();
    test_underscore();
    test_overflow();
    test_gap();
    test_back_to_back();
    test_count_sat();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
